// File: rtl/z80_pkg.sv
// Shared definitions for the Z80 mode-2 interrupt controller:
// register indices, the spurious vector index and the vector builder.
package z80_pkg;

    localparam logic [1:0] INTC_REG_VBASE = 2'd0;
    localparam logic [1:0] INTC_REG_MASK  = 2'd1;
    localparam logic [1:0] INTC_REG_PEND  = 2'd2;
    localparam logic [1:0] INTC_REG_ISR   = 2'd3;

    localparam logic [2:0] INTC_SPURIOUS_IDX = 3'd7;

    // Mode 2 requires an even vector, so bit 0 is always zero
    function automatic logic [7:0] intc_vector(input logic [3:0] base, input logic [2:0] idx);
        return {base, idx, 1'b0};
    endfunction

endpackage

// File: rtl/z80_intc_prio8.sv
// Combinational eight-input priority encoder; the lowest set index wins.
module z80_intc_prio8 (
    input  logic [7:0] i_req,
    output logic       o_valid,
    output logic [2:0] o_idx
);

    always_comb begin
        o_valid = 1'b0;
        o_idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/z80_interrupt_controller.sv
// Vectored Z80 mode-2 interrupt controller with in-service nesting.
// Define Z80_INTC_EDGE_EN for synchronised rising-edge requests with sticky PEND.
module z80_interrupt_controller
    import z80_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cs_n,
    input  logic       i_m1_n,
    input  logic       i_iorq_n,
    input  logic       i_rd_n,
    input  logic       i_wr_n,
    input  logic [1:0] i_addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_data_oe_n,
    input  logic [7:0] i_irq,
    output logic       o_int_n
);

    logic [3:0] vbase_q, vbase_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] isr_q, isr_d, isr_set;
    logic [2:0] ack_idx_q, ack_idx_d;
    logic       ack_done_q;
    logic       wr_n_prev_q;
    logic       int_n_q, int_n_d;

    logic       ack, rd_sel, wr_sel, cap, eoi;
    logic [7:0] pend, act;
    logic       act_valid, isr_valid;
    logic [2:0] act_idx, isr_idx;
    logic [3:0] isr_floor;
    logic [7:0] reg_rdata;

    assign ack    = ~i_m1_n & ~i_iorq_n;
    assign rd_sel = ~i_cs_n & ~i_rd_n;
    assign wr_sel = ~i_cs_n & ~i_wr_n;
    assign cap    = ack & ~ack_done_q;
    // EOI fires once per write strobe even though register writes repeat while it holds
    assign eoi    = wr_sel & wr_n_prev_q & (i_addr == INTC_REG_ISR);

`ifdef Z80_INTC_EDGE_EN
    logic [7:0] sync1_q, sync2_q, prev_q, pend_q, pend_d;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
            prev_q  <= 8'h00;
            pend_q  <= 8'h00;
        end else begin
            sync1_q <= i_irq;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pend_q  <= pend_d;
        end
    end

    // A fresh edge is OR-ed in last so it survives a same-cycle clear
    always_comb begin
        pend_d = pend_q;
        if (wr_sel && (i_addr == INTC_REG_PEND)) begin
            pend_d = pend_d & ~i_data;
        end
        if (cap && act_valid) begin
            pend_d[act_idx] = 1'b0;
        end
        pend_d = pend_d | (sync2_q & ~prev_q);
    end

    assign pend = pend_q;
`else
    assign pend = i_irq;
`endif

    assign act = pend & mask_q;

    z80_intc_prio8 u_act_prio (
        .i_req   (act),
        .o_valid (act_valid),
        .o_idx   (act_idx)
    );

    z80_intc_prio8 u_isr_prio (
        .i_req   (isr_q),
        .o_valid (isr_valid),
        .o_idx   (isr_idx)
    );

    assign isr_floor = isr_valid ? {1'b0, isr_idx} : 4'd8;

    always_comb begin
        vbase_d = vbase_q;
        mask_d  = mask_q;
        if (wr_sel) begin
            case (i_addr)
                INTC_REG_VBASE: vbase_d = i_data[7:4];
                INTC_REG_MASK:  mask_d  = i_data;
                default:        ;
            endcase
        end

        isr_set = isr_q;
        if (cap && act_valid) begin
            isr_set[act_idx] = 1'b1;
        end
        // Capture applies first, then EOI drops the lowest set bit
        isr_d = eoi ? (isr_set & (isr_set - 8'd1)) : isr_set;

        ack_idx_d = ack_idx_q;
        if (cap) begin
            ack_idx_d = act_valid ? act_idx : INTC_SPURIOUS_IDX;
        end

        int_n_d = ~(act_valid && ({1'b0, act_idx} < isr_floor));
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vbase_q     <= 4'h0;
            mask_q      <= 8'h00;
            isr_q       <= 8'h00;
            ack_idx_q   <= 3'd0;
            ack_done_q  <= 1'b0;
            wr_n_prev_q <= 1'b1;
            int_n_q     <= 1'b1;
        end else begin
            vbase_q     <= vbase_d;
            mask_q      <= mask_d;
            isr_q       <= isr_d;
            ack_idx_q   <= ack_idx_d;
            ack_done_q  <= ack;
            wr_n_prev_q <= i_wr_n;
            int_n_q     <= int_n_d;
        end
    end

    always_comb begin
        case (i_addr)
            INTC_REG_VBASE: reg_rdata = {vbase_q, 4'h0};
            INTC_REG_MASK:  reg_rdata = mask_q;
            INTC_REG_PEND:  reg_rdata = pend;
            default:        reg_rdata = isr_q;
        endcase
    end

    // Reset forces the bus released even while an acknowledge is still in progress
    always_comb begin
        if (i_reset) begin
            o_data = 8'h00;
        end else if (ack) begin
            o_data = intc_vector(vbase_q, ack_idx_q);
        end else if (rd_sel) begin
            o_data = reg_rdata;
        end else begin
            o_data = 8'h00;
        end
    end

    assign o_data_oe_n = i_reset | ~(ack | rd_sel);
    assign o_int_n     = int_n_q;

endmodule
